// File: rtl/mask_stream_controller.sv
`default_nettype none
// ============================================================================
// Module      : mask_stream_controller
// Description : Sequences the VGA mask path. It requests one mask row from the
//               mask generator and loads that row into the mask serializer.
//               It then steps the serializer one word per accepted beat toward
//               the downstream sink. It counts beats per row (the count depends
//               on the resolution) and rows per frame. It reports frame
//               completion, illegal configurations and generator timeouts.
// Ports       : clk, rst            - single clock, synchronous active-high reset
//               start, abort        - frame start pulse (IDLE only) / forced stop
//               continuous          - auto-restart after frame_done
//               cfg_res, cfg_rows   - frame configuration, latched in IDLE
//               mask_valid          - generator row-ready strobe
//               sink_ready          - downstream accepts the current word
//               mg_req              - request next mask row
//               ser_load, ser_next  - serializer load / advance strobes
//               ser_res             - latched resolution to the serializer
//               dout_valid          - serializer output holds a valid word
//               last_beat           - current word is the last of the row
//               row_idx             - row currently being streamed
//               busy                - controller is not idle
//               frame_done, err     - completion / error pulses
// Revision    : 1.0 - initial release
// ============================================================================
module mask_stream_controller #(
    parameter int STEP_SEL0 = 16,
    parameter int STEP_SEL1 = 32,
    parameter int STEP_SEL2 = 54,
    parameter int ROW_CNT_W = 10,
    parameter int TIMEOUT   = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 abort,
    input  logic                 continuous,
    input  logic [1:0]           cfg_res,
    input  logic [ROW_CNT_W-1:0] cfg_rows,
    input  logic                 mask_valid,
    input  logic                 sink_ready,
    output logic                 mg_req,
    output logic                 ser_load,
    output logic                 ser_next,
    output logic [1:0]           ser_res,
    output logic                 dout_valid,
    output logic                 last_beat,
    output logic [ROW_CNT_W-1:0] row_idx,
    output logic                 busy,
    output logic                 frame_done,
    output logic                 err
);

    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_REQ       = 3'd1,
        S_WAIT      = 3'd2,
        S_LOAD      = 3'd3,
        S_SHIFT     = 3'd4,
        S_ROW_END   = 3'd5,
        S_FRAME_END = 3'd6
    } state_t;

    // Index of the final word of a row for each resolution
    localparam logic [5:0] c_last0 = 6'(STEP_SEL0 - 1);
    localparam logic [5:0] c_last1 = 6'(STEP_SEL1 - 1);
    localparam logic [5:0] c_last2 = 6'(STEP_SEL2 - 1);

    // The counter value seen in the final waiting cycle. The edge that ends
    // that cycle would bring the count to TIMEOUT, so the timeout fires there.
    localparam logic [7:0] c_tmo_last = 8'(TIMEOUT - 1);

    localparam logic [ROW_CNT_W-1:0] c_row_one = {{(ROW_CNT_W-1){1'b0}}, 1'b1};

    state_t               r_state;
    logic [5:0]           r_beat;
    logic [7:0]           r_tmo;
    logic [ROW_CNT_W-1:0] r_rows;
    logic [ROW_CNT_W-1:0] r_row;
    logic [1:0]           r_res;
    logic                 r_err;

    logic [5:0]           w_last_idx;
    logic                 w_is_last;
    logic                 w_cfg_bad;
    logic                 w_shift;

    always_comb begin
        w_last_idx = c_last0;
        case (r_res)
            2'b01:   w_last_idx = c_last1;
            2'b10:   w_last_idx = c_last2;
            default: w_last_idx = c_last0;
        endcase
    end

    assign w_is_last = (r_beat == w_last_idx);
    assign w_cfg_bad = (cfg_res == 2'b11) || (cfg_rows == '0);
    assign w_shift   = (r_state == S_SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_beat  <= '0;
            r_tmo   <= '0;
            r_rows  <= '0;
            r_row   <= '0;
            r_res   <= 2'b00;
            r_err   <= 1'b0;
        end else begin
            r_err <= 1'b0;
            if (abort) begin
                // Abort leaves the controller with every output at zero.
                // It does not raise frame_done or err.
                r_state <= S_IDLE;
                r_row   <= '0;
                r_res   <= 2'b00;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            if (w_cfg_bad) begin
                                r_err <= 1'b1;
                            end else begin
                                r_res   <= cfg_res;
                                r_rows  <= cfg_rows;
                                r_row   <= '0;
                                r_state <= S_REQ;
                            end
                        end
                    end
                    S_REQ: begin
                        r_tmo   <= '0;
                        r_state <= S_WAIT;
                    end
                    S_WAIT: begin
                        if (mask_valid) begin
                            r_state <= S_LOAD;
                        end else if (r_tmo == c_tmo_last) begin
                            r_err   <= 1'b1;
                            r_state <= S_IDLE;
                        end else begin
                            r_tmo <= r_tmo + 8'd1;
                        end
                    end
                    S_LOAD: begin
                        r_beat  <= '0;
                        r_state <= S_SHIFT;
                    end
                    S_SHIFT: begin
                        // With sink_ready low, the beat count and the
                        // serializer word stay where they are.
                        if (sink_ready) begin
                            if (w_is_last) begin
                                r_state <= S_ROW_END;
                            end else begin
                                r_beat <= r_beat + 6'd1;
                            end
                        end
                    end
                    S_ROW_END: begin
                        if (r_row == (r_rows - c_row_one)) begin
                            r_state <= S_FRAME_END;
                        end else begin
                            r_row   <= r_row + c_row_one;
                            r_state <= S_REQ;
                        end
                    end
                    S_FRAME_END: begin
                        if (continuous) begin
                            r_row   <= '0;
                            r_state <= S_REQ;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    // The strobes are decoded from the registered state. abort masks them in
    // the same cycle, so nothing reaches the generator or serializer while
    // the abort is in progress.
    assign mg_req     = (r_state == S_REQ)       && !abort;
    assign ser_load   = (r_state == S_LOAD)      && !abort;
    assign dout_valid = w_shift                  && !abort;
    assign last_beat  = w_shift && w_is_last     && !abort;
    // The serializer advances on an accepted beat, except after the final
    // word of the row.
    assign ser_next   = w_shift && sink_ready && !w_is_last && !abort;
    assign frame_done = (r_state == S_FRAME_END) && !abort;
    assign err        = r_err                    && !abort;
    assign busy       = (r_state != S_IDLE);
    assign row_idx    = r_row;
    assign ser_res    = r_res;

endmodule
`default_nettype wire

// File: tb/tb_mask_stream_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_mask_stream_controller
// Description : Self-checking bench for mask_stream_controller. A cycle
//               timeline of each frame is built from the frame rules:
//               request, wait, load, one word per accepted beat, row end and
//               frame end. The bench checks every output in every cycle
//               against that timeline. The stimulus is randomized: generator
//               delay, sink backpressure, configuration, and noise on the
//               ignored inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mask_stream_controller;

    logic       clk = 1'b0;
    logic       rst, start, abort, continuous, mask_valid, sink_ready;
    logic [1:0] cfg_res;
    logic [9:0] cfg_rows;
    logic       mg_req, ser_load, ser_next, dout_valid, last_beat;
    logic       busy, frame_done, err;
    logic [1:0] ser_res;
    logic [9:0] row_idx;

    int n_cmp = 0;
    int n_bad = 0;

    // Values that row_idx and ser_res are expected to hold while idle
    logic [9:0] g_row = '0;
    logic [1:0] g_res = 2'b00;

    mask_stream_controller dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .abort      (abort),
        .continuous (continuous),
        .cfg_res    (cfg_res),
        .cfg_rows   (cfg_rows),
        .mask_valid (mask_valid),
        .sink_ready (sink_ready),
        .mg_req     (mg_req),
        .ser_load   (ser_load),
        .ser_next   (ser_next),
        .ser_res    (ser_res),
        .dout_valid (dout_valid),
        .last_beat  (last_beat),
        .row_idx    (row_idx),
        .busy       (busy),
        .frame_done (frame_done),
        .err        (err)
    );

    always #5 clk = ~clk;

    function automatic int steps_of(input logic [1:0] r);
        case (r)
            2'b01:   return 32;
            2'b10:   return 54;
            default: return 16;
        endcase
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with this cycle's inputs already driven. It checks
    // the outputs, then moves to one step past the next rising edge.
    task automatic exp_cyc(input string tag, input bit e_req, input bit e_load,
                           input bit e_next, input bit e_dv, input bit e_last,
                           input bit e_busy, input bit e_done, input bit e_err,
                           input logic [9:0] e_row, input logic [1:0] e_res);
        #1;
        chk({tag, ".mg_req"},     32'(mg_req),     32'(e_req));
        chk({tag, ".ser_load"},   32'(ser_load),   32'(e_load));
        chk({tag, ".ser_next"},   32'(ser_next),   32'(e_next));
        chk({tag, ".dout_valid"}, 32'(dout_valid), 32'(e_dv));
        chk({tag, ".last_beat"},  32'(last_beat),  32'(e_last));
        chk({tag, ".busy"},       32'(busy),       32'(e_busy));
        chk({tag, ".frame_done"}, 32'(frame_done), 32'(e_done));
        chk({tag, ".err"},        32'(err),        32'(e_err));
        chk({tag, ".row_idx"},    32'(row_idx),    32'(e_row));
        chk({tag, ".ser_res"},    32'(ser_res),    32'(e_res));
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input string tag);
        exp_cyc(tag, 0, 0, 0, 0, 0, 0, 0, 0, g_row, g_res);
    endtask

    // Runs one or more frames back to back.
    // sr_mode: 0 = sink always ready, 1 = ready toggles 1010..., 2 = random.
    // dly: wait cycles before mask_valid (0 = random 1..4).
    // abort_row >= 0 aborts when that row is presenting word abort_beat.
    task automatic run_frame(input logic [1:0] res, input int rows, input int nframes,
                             input int sr_mode, input int dly,
                             input int abort_row, input int abort_beat);
        int steps;
        int acc;
        int d;
        bit sr;
        bit tgl;
        steps      = steps_of(res);
        cfg_res    = res;
        cfg_rows   = 10'(rows);
        start      = 1'b1;
        continuous = 1'b0;
        idle("start");
        start    = 1'b0;
        cfg_res  = 2'($urandom);
        cfg_rows = 10'($urandom);
        for (int f = 0; f < nframes; f++) begin
            for (int r = 0; r < rows; r++) begin
                start = 1'($urandom);
                exp_cyc("req", 1, 0, 0, 0, 0, 1, 0, 0, 10'(r), res);
                start = 1'b0;
                d = (dly > 0) ? dly : int'($urandom_range(1, 4));
                for (int k = 1; k <= d; k++) begin
                    mask_valid = (k == d);
                    exp_cyc("wait", 0, 0, 0, 0, 0, 1, 0, 0, 10'(r), res);
                end
                mask_valid = 1'b0;
                exp_cyc("load", 0, 1, 0, 0, 0, 1, 0, 0, 10'(r), res);
                acc = 0;
                tgl = 1'b1;
                while (acc < steps) begin
                    case (sr_mode)
                        0:       sr = 1'b1;
                        1:       begin sr = tgl; tgl = !tgl; end
                        default: sr = 1'($urandom);
                    endcase
                    sink_ready = sr;
                    mask_valid = 1'($urandom);
                    continuous = 1'($urandom);
                    if (r == abort_row && acc == abort_beat) begin
                        abort = 1'b1;
                        exp_cyc("abort", 0, 0, 0, 0, 0, 1, 0, 0, 10'(r), res);
                        abort      = 1'b0;
                        sink_ready = 1'b0;
                        mask_valid = 1'b0;
                        continuous = 1'b0;
                        g_row      = '0;
                        g_res      = 2'b00;
                        idle("post_abort");
                        idle("post_abort2");
                        return;
                    end
                    exp_cyc("shift", 0, 0, sr && (acc < steps - 1), 1,
                            acc == steps - 1, 1, 0, 0, 10'(r), res);
                    if (sr) acc++;
                end
                sink_ready = 1'b0;
                mask_valid = 1'b0;
                exp_cyc("row_end", 0, 0, 0, 0, 0, 1, 0, 0, 10'(r), res);
            end
            continuous = (f < nframes - 1);
            exp_cyc("frame_end", 0, 0, 0, 0, 0, 1, 1, 0, 10'(rows - 1), res);
        end
        continuous = 1'b0;
        g_row      = 10'(rows - 1);
        g_res      = res;
        idle("after_frame");
    endtask

    initial begin
        rst        = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        continuous = 1'b0;
        mask_valid = 1'b0;
        sink_ready = 1'b0;
        cfg_res    = 2'b00;
        cfg_rows   = '0;
        @(posedge clk);
        #1;
        start = 1'b1;
        mask_valid = 1'b1;
        idle("reset");
        start      = 1'b0;
        mask_valid = 1'b0;
        rst        = 1'b0;
        idle("reset_release");

        // Single row: mask_valid 3 cycles after mg_req, sink always ready
        run_frame(2'b00, 1, 1, 0, 3, -1, 0);

        // Resolution sweep
        run_frame(2'b01, 2, 1, 0, 0, -1, 0);
        run_frame(2'b10, 2, 1, 2, 0, -1, 0);

        // Backpressure 1010...
        run_frame(2'b00, 1, 1, 1, 0, -1, 0);

        // Illegal resolution
        cfg_res  = 2'b11;
        cfg_rows = 10'd5;
        start    = 1'b1;
        idle("bad_res_start");
        start = 1'b0;
        exp_cyc("bad_res_err", 0, 0, 0, 0, 0, 0, 0, 1, g_row, g_res);
        idle("bad_res_after");

        // Zero rows
        cfg_res  = 2'b01;
        cfg_rows = 10'd0;
        start    = 1'b1;
        idle("bad_rows_start");
        start = 1'b0;
        exp_cyc("bad_rows_err", 0, 0, 0, 0, 0, 0, 0, 1, g_row, g_res);
        idle("bad_rows_after");

        // Generator timeout: 255 waiting cycles, then err with state back in IDLE
        cfg_res  = 2'b01;
        cfg_rows = 10'd1;
        start    = 1'b1;
        idle("tmo_start");
        start = 1'b0;
        exp_cyc("tmo_req", 1, 0, 0, 0, 0, 1, 0, 0, 10'd0, 2'b01);
        for (int k = 0; k < 255; k++) begin
            exp_cyc("tmo_wait", 0, 0, 0, 0, 0, 1, 0, 0, 10'd0, 2'b01);
        end
        g_row = 10'd0;
        g_res = 2'b01;
        exp_cyc("tmo_err", 0, 0, 0, 0, 0, 0, 0, 1, g_row, g_res);
        idle("tmo_after");

        // Abort at beat 7 of row 1
        run_frame(2'b00, 2, 1, 0, 0, 1, 7);

        // Reset in the middle of WAIT
        cfg_res  = 2'b10;
        cfg_rows = 10'd2;
        start    = 1'b1;
        idle("rstw_start");
        start = 1'b0;
        exp_cyc("rstw_req", 1, 0, 0, 0, 0, 1, 0, 0, 10'd0, 2'b10);
        exp_cyc("rstw_wait", 0, 0, 0, 0, 0, 1, 0, 0, 10'd0, 2'b10);
        rst        = 1'b1;
        mask_valid = 1'b1;
        exp_cyc("rstw_assert", 0, 0, 0, 0, 0, 1, 0, 0, 10'd0, 2'b10);
        rst        = 1'b0;
        mask_valid = 1'b0;
        g_row      = '0;
        g_res      = 2'b00;
        idle("rstw_after");
        idle("rstw_after2");

        // Continuous mode: two 3-row frames, stopping after the second
        run_frame(2'b00, 3, 2, 2, 0, -1, 0);

        // Randomized frames
        repeat (4) begin
            run_frame(2'($urandom_range(0, 2)), int'($urandom_range(1, 3)),
                      int'($urandom_range(1, 2)), 2, 0, -1, 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
